// File: rtl/mem_responder.sv
// Word-addressed memory responder for the cache refill/writeback port.
// One request at a time; completes after LATENCY cycles with a one-cycle mem_ready pulse.
module mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4,
  parameter int ADDR_LSB   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_ready,
  output logic [31:0] refill,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic                  r_mem_ready;
  logic                  r_busy;
  logic [31:0]           r_refill;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_op_write;
  logic [DEPTH_LOG2-1:0] w_op_idx;
  logic [31:0]           w_op_wdata;
  logic                  w_unused_addr;

  // Upper and sub-word address bits are intentionally ignored, giving modulo aliasing.
  assign w_unused_addr = &{1'b0, req_addr};

  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_enter_resp = (w_accept && (LATENCY == 1)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));

  // With LATENCY=1 the operation completes on the acceptance edge, so use the live inputs there.
  assign w_op_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_op_idx   = (r_state == S_IDLE) ? req_addr[ADDR_LSB+DEPTH_LOG2-1:ADDR_LSB] : r_idx;
  assign w_op_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 32'd0;
      r_mem_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_refill    <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
      r_mem_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_idx   <= req_addr[ADDR_LSB+DEPTH_LOG2-1:ADDR_LSB];
            r_wdata <= req_wdata;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_enter_resp) begin
        r_mem_ready <= 1'b1;
        if (!w_op_write) r_refill <= r_mem[w_op_idx];
      end
    end
  end

  // NOTE: the storage array has no reset; only control state and outputs are cleared.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_op_write) r_mem[w_op_idx] <= w_op_wdata;
  end

  assign mem_ready = r_mem_ready;
  assign busy      = r_busy;
  assign refill    = r_refill;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a LATENCY=4 and a LATENCY=1 instance share clk/rst.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        mem_ready [2];
  logic        busy      [2];
  logic [31:0] refill    [2];

  int lat [2] = '{4, 1};
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] model_mem [int];
  logic [31:0] exp_refill [2];

  typedef struct {
    int          dut;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          drop;
    bit          b2b;
  } vec_t;

  vec_t vecs [$];

  mem_responder #(.DEPTH_LOG2(8), .LATENCY(4), .ADDR_LSB(2)) u_dut_l4 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[0]),
    .req_write (req_write[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .mem_ready (mem_ready[0]),
    .refill    (refill[0]),
    .busy      (busy[0])
  );

  mem_responder #(.DEPTH_LOG2(8), .LATENCY(1), .ADDR_LSB(2)) u_dut_l1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[1]),
    .req_write (req_write[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .mem_ready (mem_ready[1]),
    .refill    (refill[1]),
    .busy      (busy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Word index inside the 256-word array, keyed separately per instance.
  function automatic int key_of(input int d, input logic [31:0] addr);
    return d * 256 + int'((addr / 4) % 256);
  endfunction

  // Issue one request from IDLE (called #1 after an edge); returns #1 after the edge leaving RESP.
  task automatic do_req(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit drop,
                        output logic [31:0] got, output int pulse_at);
    int k;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(posedge clk); #1;
    if (drop) req_valid[d] = 1'b0;
    k = key_of(d, addr);
    if (wr) model_mem[k] = wdata;
    else    exp_refill[d] = model_mem[k];
    pulse_at = -1;
    for (int c = 0; c < lat[d]; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      check("busy during request", busy[d], 1);
      check("mem_ready timing", mem_ready[d], (c == lat[d] - 1) ? 1 : 0);
    end
    pulse_at = cyc;
    got = refill[d];
    check("refill at mem_ready", refill[d], exp_refill[d]);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    check("mem_ready after RESP", mem_ready[d], 0);
    check("busy after RESP", busy[d], 0);
    check("refill held after RESP", refill[d], exp_refill[d]);
  endtask

  initial begin
    logic [31:0] got;
    int          p;
    int          prev_p;
    bit          seen;
    vec_t        v;

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      exp_refill[d] = 32'd0;
    end

    rst = 1'b1;
    #3;
    for (int d = 0; d < 2; d++) begin
      check("reset mem_ready", mem_ready[d], 0);
      check("reset busy", busy[d], 0);
      check("reset refill", refill[d], 0);
    end
    @(posedge clk); #6;
    rst = 1'b0;
    @(posedge clk); #1;

    vecs.push_back('{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1});
    vecs.push_back('{0, 1'b1, 32'h0000_0080, 32'h2222_2222, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{0, 1'b1, 32'h0000_0040, 32'h1111_1111, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{0, 1'b0, 32'h0000_0080, 32'h0,         32'h2222_2222, 1'b0, 1'b1});
    vecs.push_back('{0, 1'b0, 32'h0000_0040, 32'h0,         32'h1111_1111, 1'b1, 1'b1});
    vecs.push_back('{0, 1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{0, 1'b0, 32'h0000_0407, 32'h0,         32'hA5A5_A5A5, 1'b0, 1'b1});
    vecs.push_back('{0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{1, 1'b1, 32'h0000_0010, 32'h0123_4567, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{1, 1'b0, 32'h0000_0010, 32'h0,         32'h0123_4567, 1'b0, 1'b1});
    vecs.push_back('{1, 1'b1, 32'h0000_0014, 32'h89AB_CDEF, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{1, 1'b0, 32'h0000_0014, 32'h0,         32'h89AB_CDEF, 1'b0, 1'b1});
    vecs.push_back('{1, 1'b0, 32'hFFFF_FC12, 32'h0,         32'h0123_4567, 1'b0, 1'b1});

    prev_p = 0;
    foreach (vecs[i]) begin
      v = vecs[i];
      do_req(v.dut, v.wr, v.addr, v.wdata, v.drop, got, p);
      if (!v.wr) check("vector refill", got, v.exp);
      if (v.b2b) check("pulse spacing", p - prev_p, lat[v.dut] + 1);
      prev_p = p;
    end

    // Idle with req_valid low: everything holds.
    repeat (3) begin
      @(posedge clk); #1;
      check("idle mem_ready", mem_ready[0], 0);
      check("idle busy", busy[0], 0);
      check("idle refill hold", refill[0], 32'hA5A5_A5A5);
    end

    // Reset in the middle of a write: no completion, array keeps the prior word.
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h0000_0020;
    req_wdata[0] = 32'h1234_5678;
    @(posedge clk); #1;
    check("write accepted busy", busy[0], 1);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("async reset mem_ready", mem_ready[0], 0);
    check("async reset busy", busy[0], 0);
    check("async reset refill", refill[0], 0);
    check("async reset refill l1", refill[1], 0);
    req_valid[0] = 1'b0;
    exp_refill[0] = 32'd0;
    exp_refill[1] = 32'd0;
    @(posedge clk); #6;
    rst = 1'b0;
    seen = 1'b0;
    repeat (lat[0] + 2) begin
      @(posedge clk); #1;
      if (mem_ready[0] || busy[0]) seen = 1'b1;
    end
    check("no completion after reset", 32'(seen), 0);
    do_req(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, got, p);
    check("aborted write discarded", got, 32'hCAFE_F00D);

    // Randomized traffic against the word-array model, with aliased upper/low address bits.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 30; n++) begin
        int          idx;
        bit          wr;
        logic [31:0] addr;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          check("random idle mem_ready", mem_ready[d], 0);
        end
        idx  = $urandom_range(0, 15);
        wr   = 1'($urandom_range(0, 1));
        addr = ($urandom & 32'hFFFF_FC03) | 32'(idx * 4);
        if (!wr && !model_mem.exists(key_of(d, addr))) wr = 1'b1;
        do_req(d, wr, addr, $urandom, 1'($urandom_range(0, 1)), got, p);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
